// File: rtl/platform_collision_unit.sv
`default_nettype none
// ============================================================================
// Module      : platform_collision_unit
// Description : Per-frame landing test of a sprite hitbox against a small
//               table of horizontal platforms. On start, the sprite position
//               and platform table are captured. One platform is then
//               evaluated per cycle, and the topmost hit (smallest platform y,
//               lowest index on ties) is reported with a one-cycle done pulse.
// Ports       : clk, reset (async, active-high)
//               start                      - one-cycle frame request
//               x_pos, y_pos, next_y       - sprite left x, top y, proposed top y
//               drop_req                   - drop-through request
//               plt_x, plt_y, plt_w        - packed platform table, slice i = plt i
//               busy, done                 - scan in progress / result-valid pulse
//               landed, plt_idx, snap_y    - result, held until next done
// Config      : define PLT_DROP_THRU_EN to make platforms 1..NUM_PLT-1 one-way
//               (ignored while the latched drop_req is high). Platform 0 stays
//               solid.
// Revision    : 1.0 - initial release
// ============================================================================
module platform_collision_unit #(
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 16,
    parameter int NUM_PLT = 4,
    parameter int COORD_W = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [COORD_W-1:0]         x_pos,
    input  logic [COORD_W-1:0]         y_pos,
    input  logic [COORD_W-1:0]         next_y,
    input  logic                       drop_req,
    input  logic [NUM_PLT*COORD_W-1:0] plt_x,
    input  logic [NUM_PLT*COORD_W-1:0] plt_y,
    input  logic [NUM_PLT*COORD_W-1:0] plt_w,
    output logic                       busy,
    output logic                       done,
    output logic                       landed,
    output logic [2:0]                 plt_idx,
    output logic [COORD_W-1:0]         snap_y
);

    // Comparisons run two bits wider than the coordinates so that sums such
    // as y + 2*HEIGHT and px + pw can never wrap.
    localparam logic [COORD_W+1:0] c_W2   = (COORD_W+2)'(2 * WIDTH);
    localparam logic [COORD_W+1:0] c_H2   = (COORD_W+2)'(2 * HEIGHT);
    localparam logic [COORD_W-1:0] c_H2_N = COORD_W'(2 * HEIGHT);
    localparam logic [2:0]         c_LAST = 3'(NUM_PLT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [2:0]           r_idx;
    logic [COORD_W-1:0]   r_x;
    logic [COORD_W-1:0]   r_y;
    logic [COORD_W-1:0]   r_ny;
    logic [COORD_W-1:0]   r_px [NUM_PLT];
    logic [COORD_W-1:0]   r_py [NUM_PLT];
    logic [COORD_W-1:0]   r_pw [NUM_PLT];
    logic                 r_best_valid;
    logic [COORD_W-1:0]   r_best_py;
    logic [2:0]           r_best_idx;

    logic [COORD_W-1:0]   w_px;
    logic [COORD_W-1:0]   w_py;
    logic [COORD_W-1:0]   w_pw;
    logic                 w_drop_block;
    logic                 w_hit;
    logic                 w_take;
    logic                 w_fin_valid;
    logic [COORD_W-1:0]   w_fin_py;
    logic [2:0]           w_fin_idx;

`ifdef PLT_DROP_THRU_EN
    logic                 r_drop;
    assign w_drop_block = r_drop && (r_idx != 3'd0);
`else
    // drop_req has no effect in this build.
    logic                 w_unused_drop;
    assign w_unused_drop = drop_req;
    assign w_drop_block  = 1'b0;
`endif

    // Select the platform currently under evaluation.
    always_comb begin
        w_px = '0;
        w_py = '0;
        w_pw = '0;
        for (int i = 0; i < NUM_PLT; i++) begin
            if (r_idx == 3'(i)) begin
                w_px = r_px[i];
                w_py = r_py[i];
                w_pw = r_pw[i];
            end
        end
    end

    always_comb begin
        w_hit = (({2'b00, r_y}  + c_H2) <= {2'b00, w_py}) &&
                (({2'b00, r_ny} + c_H2) >= {2'b00, w_py}) &&
                (({2'b00, r_x}  + c_W2) >= {2'b00, w_px}) &&
                ({2'b00, r_x} <= ({2'b00, w_px} + {2'b00, w_pw})) &&
                !w_drop_block;
        // Strictly smaller py replaces: indices ascend, so ties keep the lower index.
        w_take      = w_hit && (!r_best_valid || (w_py < r_best_py));
        w_fin_valid = w_take || r_best_valid;
        w_fin_py    = w_take ? w_py  : r_best_py;
        w_fin_idx   = w_take ? r_idx : r_best_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= 3'd0;
            r_x          <= '0;
            r_y          <= '0;
            r_ny         <= '0;
            r_best_valid <= 1'b0;
            r_best_py    <= '0;
            r_best_idx   <= 3'd0;
            for (int i = 0; i < NUM_PLT; i++) begin
                r_px[i] <= '0;
                r_py[i] <= '0;
                r_pw[i] <= '0;
            end
`ifdef PLT_DROP_THRU_EN
            r_drop       <= 1'b0;
`endif
            busy         <= 1'b0;
            done         <= 1'b0;
            landed       <= 1'b0;
            plt_idx      <= 3'd0;
            snap_y       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_x          <= x_pos;
                        r_y          <= y_pos;
                        r_ny         <= next_y;
                        for (int i = 0; i < NUM_PLT; i++) begin
                            r_px[i] <= plt_x[i*COORD_W +: COORD_W];
                            r_py[i] <= plt_y[i*COORD_W +: COORD_W];
                            r_pw[i] <= plt_w[i*COORD_W +: COORD_W];
                        end
`ifdef PLT_DROP_THRU_EN
                        r_drop       <= drop_req;
`endif
                        r_idx        <= 3'd0;
                        r_best_valid <= 1'b0;
                        r_best_py    <= '0;
                        r_best_idx   <= 3'd0;
                        busy         <= 1'b1;
                        r_state      <= SCAN;
                    end
                end
                SCAN: begin
                    r_best_valid <= w_fin_valid;
                    r_best_py    <= w_fin_py;
                    r_best_idx   <= w_fin_idx;
                    if (r_idx == c_LAST) begin
                        // Final result uses the just-evaluated platform directly.
                        done    <= 1'b1;
                        landed  <= w_fin_valid;
                        plt_idx <= w_fin_valid ? w_fin_idx : 3'd0;
                        snap_y  <= w_fin_valid ? (w_fin_py - c_H2_N) : r_ny;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_idx   <= 3'd0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_platform_collision_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_platform_collision_unit
// Description : Self-checking bench for platform_collision_unit. Directed
//               frames on the reference platform table plus randomized frames,
//               compared against a behavioural landing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_platform_collision_unit;

    localparam int WIDTH   = 16;
    localparam int HEIGHT  = 16;
    localparam int NUM_PLT = 4;
    localparam int COORD_W = 10;
`ifdef PLT_DROP_THRU_EN
    localparam bit c_DROP = 1'b1;
`else
    localparam bit c_DROP = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic [COORD_W-1:0]         x_pos, y_pos, next_y;
    logic                       drop_req;
    logic [NUM_PLT*COORD_W-1:0] plt_x, plt_y, plt_w;
    logic                       busy, done, landed;
    logic [2:0]                 plt_idx;
    logic [COORD_W-1:0]         snap_y;

    int tx [NUM_PLT];
    int ty [NUM_PLT];
    int tw [NUM_PLT];

    int n_cmp = 0;
    int n_err = 0;

    platform_collision_unit #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_PLT(NUM_PLT), .COORD_W(COORD_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .x_pos(x_pos), .y_pos(y_pos), .next_y(next_y), .drop_req(drop_req),
        .plt_x(plt_x), .plt_y(plt_y), .plt_w(plt_w),
        .busy(busy), .done(done), .landed(landed),
        .plt_idx(plt_idx), .snap_y(snap_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Landing model: plain-integer evaluation of every platform, keep the
    // topmost hit, ties go to the lower index.
    function automatic void ref_eval(input int x, input int y, input int ny,
                                     input bit drp,
                                     output int e_land, output int e_idx,
                                     output int e_snap);
        bit found = 1'b0;
        int best_py = 0;
        int best_i = 0;
        for (int i = 0; i < NUM_PLT; i++) begin
            bit hit;
            hit = (y + 2*HEIGHT <= ty[i]) && (ny + 2*HEIGHT >= ty[i]) &&
                  (x + 2*WIDTH >= tx[i]) && (x <= tx[i] + tw[i]);
            if (c_DROP && drp && i >= 1) hit = 1'b0;
            if (hit && (!found || ty[i] < best_py)) begin
                found   = 1'b1;
                best_py = ty[i];
                best_i  = i;
            end
        end
        e_land = found ? 1 : 0;
        e_idx  = found ? best_i : 0;
        e_snap = found ? best_py - 2*HEIGHT : ny;
    endfunction

    task automatic load_table();
        for (int i = 0; i < NUM_PLT; i++) begin
            plt_x[i*COORD_W +: COORD_W] = COORD_W'(tx[i]);
            plt_y[i*COORD_W +: COORD_W] = COORD_W'(ty[i]);
            plt_w[i*COORD_W +: COORD_W] = COORD_W'(tw[i]);
        end
    endtask

    task automatic set_ref_table();
        tx[0] = 20;  ty[0] = 410; tw[0] = 400;
        tx[1] = 60;  ty[1] = 300; tw[1] = 100;
        tx[2] = 260; ty[2] = 300; tw[2] = 100;
        tx[3] = 160; ty[3] = 200; tw[3] = 100;
        load_table();
    endtask

    // One frame: start, scrub inputs during the scan when noisy, optionally
    // re-pulse start in cycle 2, then check latency, result and hold.
    task automatic run_frame(input string tag, input int x, input int y,
                             input int ny, input bit drp, input bit noisy,
                             input bit restart);
        int el, ei, es;
        int cyc;
        bit seen;
        ref_eval(x, y, ny, drp, el, ei, es);
        @(negedge clk);
        x_pos = COORD_W'(x); y_pos = COORD_W'(y); next_y = COORD_W'(ny);
        drop_req = drp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        seen = 1'b0;
        while (cyc <= 20) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            check({tag, "_busy"}, int'(busy), 1);
            start = 1'b0;
            if (noisy) begin
                x_pos = COORD_W'($urandom); y_pos = COORD_W'($urandom);
                next_y = COORD_W'($urandom); drop_req = 1'($urandom);
                plt_x = (NUM_PLT*COORD_W)'({$urandom, $urandom});
                plt_y = (NUM_PLT*COORD_W)'({$urandom, $urandom});
                plt_w = (NUM_PLT*COORD_W)'({$urandom, $urandom});
                start = 1'($urandom);
            end
            if (restart && cyc == 2) begin
                x_pos = 10'd430; y_pos = 10'd370; next_y = 10'd380;
                start = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, int'(seen), 1);
        if (seen) begin
            check({tag, "_latency"}, cyc, NUM_PLT + 1);
            check({tag, "_busy_done"}, int'(busy), 1);
            check({tag, "_landed"}, int'(landed), el);
            check({tag, "_plt_idx"}, int'(plt_idx), ei);
            check({tag, "_snap_y"}, int'(snap_y), es);
        end
        load_table();
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_hold_landed"}, int'(landed), el);
        check({tag, "_hold_snap"}, int'(snap_y), es);
        repeat (2) begin
            @(negedge clk);
            check({tag, "_no_extra_done"}, int'(done), 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; drop_req = 1'b0;
        x_pos = '0; y_pos = '0; next_y = '0;
        set_ref_table();
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_landed", int'(landed), 0);
        check("rst_plt_idx", int'(plt_idx), 0);
        check("rst_snap_y", int'(snap_y), 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed frames on the reference table.
        run_frame("land_p1", 100, 260, 270, 1'b0, 1'b0, 1'b0);
        check("land_p1_idx_const", int'(plt_idx), 1);
        check("land_p1_snap_const", int'(snap_y), 268);
        run_frame("cross_two", 100, 100, 400, 1'b0, 1'b0, 1'b0);
        run_frame("off_edge", 430, 370, 380, 1'b0, 1'b0, 1'b0);
        run_frame("drop_req", 100, 260, 270, 1'b1, 1'b0, 1'b0);
        run_frame("land_again", 100, 260, 270, 1'b0, 1'b0, 1'b0);

        // Abort a scan with reset in cycle 2.
        @(negedge clk);
        x_pos = 10'd100; y_pos = 10'd260; next_y = 10'd270; drop_req = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_landed", int'(landed), 0);
        check("abort_plt_idx", int'(plt_idx), 0);
        check("abort_snap_y", int'(snap_y), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_done", int'(done), 0);
        end
        run_frame("after_abort", 430, 370, 380, 1'b0, 1'b0, 1'b0);

        // Second start mid-scan must be ignored.
        run_frame("restart", 100, 260, 270, 1'b0, 1'b0, 1'b1);

        // Inputs scrambled during the scan must not affect the result.
        run_frame("noisy", 100, 100, 400, 1'b0, 1'b1, 1'b0);

        // Randomized tables and sprites.
        for (int f = 0; f < 40; f++) begin
            int x, y, ny;
            x  = $urandom_range(0, 1000);
            y  = $urandom_range(0, 700);
            ny = y + $urandom_range(0, 300);
            if (ny > 1023) ny = 1023;
            for (int i = 0; i < NUM_PLT; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    ty[i] = y + 2*HEIGHT + $urandom_range(0, ny - y);
                    if (ty[i] > 1023) ty[i] = 1023;
                    tx[i] = $urandom_range(0, (x + 2*WIDTH > 1023) ? 1023 : x + 2*WIDTH);
                end else begin
                    ty[i] = $urandom_range(0, 1023);
                    tx[i] = $urandom_range(0, 1023);
                end
                tw[i] = $urandom_range(0, 200);
                if (i > 0 && $urandom_range(0, 3) == 0) ty[i] = ty[i-1];
            end
            load_table();
            run_frame("random", x, y, ny, 1'($urandom), f[0], 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/platform_collision_unit.md
PLATFORM_COLLISION_UNIT -- requirements
Module: platform_collision_unit

Interface
REQ-001 Parameter WIDTH, default 16: sprite half-width in pixels; the hitbox spans 2*WIDTH.
REQ-002 Parameter HEIGHT, default 16: sprite half-height in pixels; the hitbox spans 2*HEIGHT.
REQ-003 Parameter NUM_PLT, default 4, legal range 1..8: number of platforms scanned.
REQ-004 Parameter COORD_W, default 10: coordinate width in bits.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset. The ports are clk and reset.
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to evaluate one frame.
REQ-009 x_pos, y_pos, next_y  in  COORD_W each  sprite left x, current top y, and proposed top y.
REQ-010 drop_req  in  1  player requests a drop-through.
REQ-011 plt_x, plt_y, plt_w  in  NUM_PLT*COORD_W each  packed platform table; slice i holds platform i (left x, top y, width).
REQ-012 busy  out  1  scan in progress.
REQ-013 done  out  1  one-cycle result-valid pulse.
REQ-014 landed  out  1  sprite lands this frame.
REQ-015 plt_idx  out  3  index of the platform landed on.
REQ-016 snap_y  out  COORD_W  corrected top y.

Function
REQ-017 FSM states are IDLE, SCAN and DONE.
- IDLE->SCAN on start.
- SCAN->DONE after index NUM_PLT-1 is evaluated.
- DONE->IDLE unconditionally.
REQ-018 On start in IDLE, the block SHALL latch x_pos, y_pos, next_y, drop_req and the full platform table. It SHALL clear the running best and set the scan index to 0.
REQ-019 SCAN SHALL evaluate exactly one platform per cycle, at index 0 through NUM_PLT-1.
REQ-020 Platform i SHALL be a hit when all four conditions below are true:
- y+2*HEIGHT <= py
- next_y+2*HEIGHT >= py
- x+2*WIDTH >= px
- x <= px+pw
REQ-021 All comparisons SHALL be done at COORD_W+2 bits, unsigned, with no wrap-around.
REQ-022 When several platforms hit, the block SHALL select the hit with the smallest py. On equal py, the lowest index wins.
REQ-023 Latency: with start sampled at cycle 0, done SHALL be high in cycle NUM_PLT+1 for exactly one cycle. busy SHALL be high in cycles 1..NUM_PLT+1.
REQ-024 In the done cycle, the block SHALL update landed, plt_idx and snap_y. On a hit, snap_y = py-2*HEIGHT and plt_idx = the winning index.
REQ-025 On no hit, the block SHALL set landed=0, plt_idx=0 and snap_y = the latched next_y.
REQ-026 Result outputs SHALL hold their values until the next done pulse.
REQ-027 start while busy SHALL be ignored. Latched inputs SHALL NOT change mid-scan.
REQ-028 With NUM_PLT=1, done SHALL occur in cycle 2.

Reset
REQ-029 Asserting reset at any time, including mid-SCAN, SHALL immediately:
- set the FSM to IDLE and the scan index to 0;
- set busy=0, done=0, landed=0, plt_idx=0 and snap_y=0.
REQ-030 An aborted scan SHALL produce no done pulse. The first start after reset deassertion SHALL be honoured.

Configuration
REQ-031 Macro PLT_DROP_THRU_EN defined: platforms with index >= 1 are one-way. When the latched drop_req=1, those platforms SHALL be treated as non-hits. Platform 0 (the main stage) always remains solid.
REQ-032 Macro PLT_DROP_THRU_EN undefined: drop_req SHALL be ignored and all platforms are solid.

Verification
Bench setup: WIDTH=HEIGHT=16 and NUM_PLT=4, with this platform table.

| Platform | x | y | w |
|---|---|---|---|
| 0 | 20 | 410 | 400 |
| 1 | 60 | 300 | 100 |
| 2 | 260 | 300 | 100 |
| 3 | 160 | 200 | 100 |

REQ-033 x=100, y=260, next_y=270, start -> done in cycle 5, landed=1, plt_idx=1, snap_y=268.
REQ-034 x=100, y=100, next_y=400 (crosses platforms 1 and 0) -> landed=1, plt_idx=1, snap_y=268. This checks the smallest-py rule.
REQ-035 x=430, y=370, next_y=380 (off the right edge of every platform) -> landed=0, plt_idx=0, snap_y=380.
REQ-036 Stimulus as REQ-033 with drop_req=1 -> landed=0 with PLT_DROP_THRU_EN defined. Without the macro, the result is as REQ-033.
REQ-037 Start a scan, assert reset in cycle 2 and release it, then issue a second start as REQ-035 -> no done from the first scan; the second done arrives 5 cycles after its start with landed=0.
REQ-038 Pulse start again in cycle 2 of a scan -> only one done pulse occurs, and the result matches the first request.
